seed_ram_wb_arbiter: RTL and testbench
======================================

Name: seed_ram_wb_arbiter

Overview:
- Shares the single Wishbone slave port of the seed RAM between three masters:
  - M0: the seed-RAM init engine.
  - M1: the CPU data bus.
  - M2: the seed-update crypto engine.
- Sits between the masters and the seed RAM slave.
- Arbitration policy: fixed highest priority for M0; round-robin between M1 and M2; grant locked for a whole Wishbone cycle.
- A per-transfer watchdog aborts hung transfers with err so no master can deadlock the RAM.

Parameters:
- dw, 32, data width.
- aw, 32, address width.
- TMO, 16, cycles without ack/err on a granted strobe before abort (≥2).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous reset, active-high; `OR1200_RST_VALUE is 1 for this block.
- mN_cyc_i, mN_stb_i, mN_we_i  in  1 each  Wishbone cycle/strobe/write from master N (N=0,1,2).
- mN_sel_i  in  4  byte selects from master N.
- mN_adr_i  in  aw  address from master N.
- mN_dat_i  in  dw  write data from master N.
- mN_dat_o  out  dw  read data to master N.
- mN_ack_o, mN_err_o  out  1 each  ack/err to master N.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to seed RAM.
- s_sel_o  out  4  to seed RAM.
- s_adr_o  out  aw  to seed RAM.
- s_dat_o  out  dw  to seed RAM.
- s_dat_i  in  dw  from seed RAM.
- s_ack_i, s_err_i  in  1 each  from seed RAM.
- gnt_o  out  2  current owner: 0/1/2, 3 = none.
- tmo_o  out  1  one-cycle pulse when a watchdog abort fires.

Behaviour:
- Reset (async, rst=1):
  - State IDLE, gnt_o=3, last-served pointer=M2 (so M1 wins the first M1/M2 tie), watchdog=0.
  - All s_* outputs 0; all mN_ack_o/mN_err_o 0; tmo_o 0.
  - rst asserted mid-transfer drops s_cyc_o immediately (asynchronous). The transfer is lost; no ack/err is delivered.
- States:
  - IDLE: no grant.
  - OWN: grant held by gnt_o.
  - ABORT: watchdog fired; waiting for the owner to drop cyc.
- IDLE → OWN:
  - Sampled on the clock edge where any mN_cyc_i=1.
  - Winner: M0 if m0_cyc_i; otherwise the requesting one of M1/M2. If both request, the one not last served wins.
  - Winner is registered into gnt_o; one-cycle arbitration latency.
- OWN, datapath (combinational from gnt_o):
  - s_cyc_o=mG_cyc_i, s_stb_o=mG_stb_i; we/sel/adr/dat muxed from owner G.
  - s_dat_i fans out to every mN_dat_o; only mG sees ack/err.
  - Non-owners see ack=err=0 and stall.
- OWN → IDLE:
  - On the edge where mG_cyc_i=0; gnt_o returns to 3.
  - Last-served pointer updates only when G is 1 or 2.
  - This gives one dead cycle between owners, so M0 preempts only at cycle boundaries, never mid-cycle.
- Watchdog:
  - Counts clocks while in OWN with s_stb_o=1 and s_ack_i=0 and s_err_i=0.
  - Clears on s_ack_i, s_err_i, s_stb_o=0, or leaving OWN.
  - When the count reaches TMO-1 with the stall still present:
    - Next cycle: state ABORT, mG_err_o=1 for exactly one cycle, tmo_o=1 for one cycle.
    - s_cyc_o/s_stb_o forced 0 from entry to ABORT.
- ABORT:
  - Late s_ack_i/s_err_i are ignored (never forwarded).
  - Exits to IDLE on the edge where mG_cyc_i=0.
- Simultaneous events:
  - s_ack_i and the watchdog threshold in the same cycle: ack wins; counter clears; no abort.
  - mG_cyc_i drop and the watchdog threshold in the same cycle: go to IDLE; no err.
- Block transfers: the owner may issue multiple stb/ack pairs within one cyc; grant holds throughout.
- Watchdog counter width: clog2(TMO); must not wrap.

Test Plan:
- Reset then M1 single write (adr 0x100, dat 0xA5A5A5A5):
  - gnt_o=1 one cycle after m1_cyc_i.
  - s_* mirror M1.
  - m1_ack_o follows s_ack_i same cycle.
  - gnt_o=3 the cycle after m1_cyc_i drops.
- M1 and M2 assert cyc on the same edge, repeated 4 back-to-back single transfers each:
  - Grant order is 1,2,1,2,….
  - Each master receives exactly 4 acks.
- M2 in mid 8-beat block transfer, M0 asserts cyc:
  - M2 keeps its grant until its cyc drops.
  - M0 is granted next, even though M1 is also requesting.
  - M1 is served after M0.
- Slave never acks M1 strobe, TMO=16:
  - m1_err_o and tmo_o pulse exactly 16 cycles after stb presentation.
  - s_cyc_o=0 from that cycle.
  - Late s_ack_i is not forwarded.
  - gnt_o=3 after m1_cyc_i drops.
- s_ack_i coincident with the watchdog threshold cycle: no err, no tmo_o, normal ack.
- rst pulsed asynchronously mid-transfer (between clock edges) while M2 is granted:
  - All s_* outputs 0, gnt_o=3 immediately.
  - After release, M0 request is granted in one cycle.

Source files
------------

// File: rtl/seed_ram_wb_arbiter.sv
// seed_ram_wb_arbiter: shares the seed RAM Wishbone slave between three masters
// (M0 fixed priority, M1/M2 round-robin), with a per-transfer abort watchdog.
module seed_ram_wb_arbiter #(
    parameter int dw  = 32,
    parameter int aw  = 32,
    parameter int TMO = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [aw-1:0] m0_adr_i,
    input  logic [dw-1:0] m0_dat_i,
    output logic [dw-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [aw-1:0] m1_adr_i,
    input  logic [dw-1:0] m1_dat_i,
    output logic [dw-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    input  logic          m2_cyc_i,
    input  logic          m2_stb_i,
    input  logic          m2_we_i,
    input  logic [3:0]    m2_sel_i,
    input  logic [aw-1:0] m2_adr_i,
    input  logic [dw-1:0] m2_dat_i,
    output logic [dw-1:0] m2_dat_o,
    output logic          m2_ack_o,
    output logic          m2_err_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_sel_o,
    output logic [aw-1:0] s_adr_o,
    output logic [dw-1:0] s_dat_o,
    input  logic [dw-1:0] s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    output logic [1:0]    gnt_o,
    output logic          tmo_o
);
    localparam int cw = (TMO > 2) ? $clog2(TMO) : 1;
    localparam logic [cw-1:0] WD_MAX = cw'(TMO - 1);
    localparam logic [1:0] IDLE = 2'd0, OWN = 2'd1, ABORT = 2'd2;

    logic [1:0]    state_q, state_d, gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [cw-1:0] wd_q, wd_d;
    logic          tmo_q, tmo_d;
    logic          none, own, own_cyc, own_stb, fwd_ack, fwd_err, stall;

    assign none    = gnt_q == 2'd3;
    assign own     = state_q == OWN;
    assign own_cyc = !none && (gnt_q[1] ? m2_cyc_i : gnt_q[0] ? m1_cyc_i : m0_cyc_i);
    assign own_stb = !none && (gnt_q[1] ? m2_stb_i : gnt_q[0] ? m1_stb_i : m0_stb_i);
    assign s_cyc_o = own && own_cyc;
    assign s_stb_o = own && own_stb;
    assign s_we_o  = !none && (gnt_q[1] ? m2_we_i : gnt_q[0] ? m1_we_i : m0_we_i);
    assign s_sel_o = none ? '0 : gnt_q[1] ? m2_sel_i : gnt_q[0] ? m1_sel_i : m0_sel_i;
    assign s_adr_o = none ? '0 : gnt_q[1] ? m2_adr_i : gnt_q[0] ? m1_adr_i : m0_adr_i;
    assign s_dat_o = none ? '0 : gnt_q[1] ? m2_dat_i : gnt_q[0] ? m1_dat_i : m0_dat_i;

    // Slave responses reach the owner only while in OWN; late ones during ABORT are dropped.
    assign fwd_ack  = own && s_ack_i;
    assign fwd_err  = (own && s_err_i) || tmo_q;
    assign m0_ack_o = fwd_ack && gnt_q == 2'd0;
    assign m1_ack_o = fwd_ack && gnt_q == 2'd1;
    assign m2_ack_o = fwd_ack && gnt_q == 2'd2;
    assign m0_err_o = fwd_err && gnt_q == 2'd0;
    assign m1_err_o = fwd_err && gnt_q == 2'd1;
    assign m2_err_o = fwd_err && gnt_q == 2'd2;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m2_dat_o = s_dat_i;
    assign gnt_o    = gnt_q;
    assign tmo_o    = tmo_q;
    assign stall    = s_stb_o && !s_ack_i && !s_err_i;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        wd_d    = '0;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: if (m0_cyc_i || m1_cyc_i || m2_cyc_i) begin
                state_d = OWN;
                gnt_d   = m0_cyc_i ? 2'd0 : (m1_cyc_i && (!m2_cyc_i || last_q)) ? 2'd1 : 2'd2;
            end
            OWN: if (!own_cyc) begin
                state_d = IDLE;
                gnt_d   = 2'd3;
                last_d  = (gnt_q == 2'd0) ? last_q : gnt_q[1];
            end else if (stall) begin
                state_d = (wd_q == WD_MAX) ? ABORT : OWN;
                tmo_d   = wd_q == WD_MAX;
                wd_d    = (wd_q == WD_MAX) ? '0 : wd_q + 1'b1;
            end
            default: if (!own_cyc) begin
                state_d = IDLE;
                gnt_d   = 2'd3;
            end
        endcase
    end

    // last_q=1 means M2 was served last, so M1 wins the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'd3;
            last_q  <= 1'b1;
            wd_q    <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            tmo_q   <= tmo_d;
        end
    end
endmodule

// File: tb/tb_seed_ram_wb_arbiter.sv
// tb_seed_ram_wb_arbiter: directed and randomized checks of the seed RAM arbiter
// against a transaction-level reference (memory model plus arbitration rules).
module tb_seed_ram_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_cyc[3], m_stb[3], m_we[3], m_ack[3], m_err[3];
    logic [3:0]  m_sel[3];
    logic [31:0] m_adr[3], m_dat[3], m_dat_o[3];
    logic        s_cyc_o, s_stb_o, s_we_o, s_ack, s_err, tmo_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat;
    logic [1:0]  gnt_o;

    int n_chk = 0, n_fail = 0;
    int slv_mode = 0, lat = 0, lat_max = 0, err_next = 0;
    logic [31:0] slv_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    logic [1:0]  gseq[$];
    logic [1:0]  pg, last_m, exp_g;
    logic        pcyc[3], aborted, stray;

    always #5 clk = ~clk;

    seed_ram_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_dat_o(m_dat_o[0]), .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_dat_o(m_dat_o[1]), .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]),
        .m2_cyc_i(m_cyc[2]), .m2_stb_i(m_stb[2]), .m2_we_i(m_we[2]), .m2_sel_i(m_sel[2]),
        .m2_adr_i(m_adr[2]), .m2_dat_i(m_dat[2]), .m2_dat_o(m_dat_o[2]), .m2_ack_o(m_ack[2]), .m2_err_o(m_err[2]),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
        .gnt_o(gnt_o), .tmo_o(tmo_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Slave model: memory with random wait states; mode 1 leaves s_ack/s_err to directed code.
    initial begin
        int wcnt = 0;
        s_ack = 0; s_err = 0; s_dat = 0;
        forever begin
            @(posedge clk); #2;
            if (slv_mode == 0) begin
                if (s_ack || s_err) begin
                    s_ack = 0; s_err = 0; wcnt = 0;
                end else if (s_cyc_o && s_stb_o) begin
                    if (wcnt >= lat) begin
                        if (err_next != 0) begin
                            s_err = 1; err_next = 0;
                        end else begin
                            s_ack = 1;
                            if (s_we_o) slv_mem[s_adr_o] = s_dat_o;
                            s_dat = slv_mem.exists(s_adr_o) ? slv_mem[s_adr_o] : 32'h0;
                        end
                        lat = $urandom_range(0, lat_max);
                    end else wcnt++;
                end else wcnt = 0;
            end
        end
    end

    // Monitor: arbitration rule, dead cycle between owners, owner-only ack/err, datapath mirror.
    initial begin
        pg = 3; last_m = 2; aborted = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pg = 3; last_m = 2; aborted = 0;
            end else begin
                if (pg == 3 && gnt_o != 3) begin
                    exp_g = pcyc[0] ? 2'd0 : (pcyc[1] && pcyc[2]) ? ((last_m == 2) ? 2'd1 : 2'd2) : pcyc[1] ? 2'd1 : 2'd2;
                    check("arb_winner", gnt_o, exp_g);
                    gseq.push_back(gnt_o);
                end
                check("gnt_hop", (pg != 3 && gnt_o != 3 && pg != gnt_o), 0);
                aborted = aborted | tmo_o;
                stray = 0;
                for (int n = 0; n < 3; n++)
                    if (n != int'(gnt_o) && (m_ack[n] || m_err[n])) stray = 1;
                check("stray_resp", stray, 0);
                if (gnt_o != 3) begin
                    check("s_cyc_mirror", s_cyc_o, aborted ? 1'b0 : m_cyc[gnt_o]);
                    check("s_adr_mirror", s_adr_o, m_adr[gnt_o]);
                end
                if (pg != 3 && pg != 0 && gnt_o == 3 && !aborted) last_m = pg;
                if (gnt_o == 3) aborted = 0;
                pg = gnt_o;
            end
            pcyc = m_cyc;
        end
    end

    task automatic clear_masters();
        for (int n = 0; n < 3; n++) begin
            m_cyc[n] = 0; m_stb[n] = 0; m_we[n] = 0; m_sel[n] = 0; m_adr[n] = 0; m_dat[n] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1; clear_masters();
        slv_mode = 0; s_ack = 0; s_err = 0; lat = 0; err_next = 0;
        repeat (2) @(posedge clk);
        #2 rst = 0;
    endtask

    task automatic xfer(input int m, input int n, input logic we, input logic [31:0] adr,
                        output int acks, output int errs);
        logic [31:0] a, d;
        int t;
        acks = 0; errs = 0;
        @(posedge clk); #1;
        m_cyc[m] = 1;
        for (int b = 0; b < n; b++) begin
            a = adr + 32'(4 * b); d = $urandom;
            m_stb[m] = 1; m_we[m] = we; m_adr[m] = a; m_dat[m] = d; m_sel[m] = 4'hf;
            t = 0;
            do begin @(negedge clk); t++; end while (!(m_ack[m] || m_err[m]) && t < 300);
            if (m_err[m]) begin
                errs++;
                @(posedge clk); #1;
                break;
            end else if (m_ack[m]) begin
                acks++;
                if (we) ref_mem[a] = d;
                else check($sformatf("rdata_m%0d", m), m_dat_o[m], ref_mem.exists(a) ? ref_mem[a] : 32'h0);
            end else begin
                check($sformatf("xfer_timeout_m%0d", m), 1, 0);
                break;
            end
            @(posedge clk); #1;
        end
        m_cyc[m] = 0; m_stb[m] = 0; m_we[m] = 0;
    endtask

    task automatic rnd_master(input int m, input int iters);
        int a, e, got = 0, want = 0, nb;
        repeat (iters) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            nb = $urandom_range(1, 4);
            want += nb;
            xfer(m, nb, 1'($urandom_range(0, 1)), (m << 8) | ($urandom_range(0, 7) << 2), a, e);
            got += a;
        end
        check($sformatf("rnd_acks_m%0d", m), got, want);
    endtask

    task automatic raise_m1_read();
        @(posedge clk); #1;
        m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 0; m_adr[1] = 32'h180; m_sel[1] = 4'hf;
    endtask

    initial begin
        int a1, a2, e1, a0, e0, k;
        clear_masters();
        #30;
        check("rst_gnt", gnt_o, 3);
        check("rst_s_cyc", {s_cyc_o, s_stb_o, s_we_o}, 0);
        check("rst_resp", {m_ack[0], m_ack[1], m_ack[2], m_err[0], m_err[1], m_err[2], tmo_o}, 0);
        do_reset();

        // single M1 write
        @(posedge clk); #1;
        m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 1; m_adr[1] = 32'h100; m_dat[1] = 32'hA5A5A5A5; m_sel[1] = 4'hf;
        @(negedge clk);
        check("w_gnt_before", gnt_o, 3);
        @(negedge clk);
        check("w_gnt", gnt_o, 1);
        check("w_s_bus", {s_cyc_o, s_stb_o, s_we_o, s_sel_o}, 7'h7f);
        check("w_s_adr", s_adr_o, 32'h100);
        check("w_s_dat", s_dat_o, 32'hA5A5A5A5);
        check("w_ack", {m_ack[1], s_ack}, 2'b11);
        ref_mem[32'h100] = 32'hA5A5A5A5;
        @(posedge clk); #1;
        m_cyc[1] = 0; m_stb[1] = 0; m_we[1] = 0;
        @(negedge clk);
        check("w_gnt_hold", gnt_o, 1);
        @(negedge clk);
        check("w_gnt_release", gnt_o, 3);

        // M1/M2 tie, round-robin
        do_reset(); lat_max = 2; gseq.delete();
        a1 = 0; a2 = 0;
        fork
            begin int a, e; repeat (4) begin xfer(1, 1, 1, 32'h104, a, e); a1 += a; end end
            begin int a, e; repeat (4) begin xfer(2, 1, 1, 32'h204, a, e); a2 += a; end end
        join
        check("rr_acks_m1", a1, 4);
        check("rr_acks_m2", a2, 4);
        check("rr_count", gseq.size(), 8);
        for (int i = 0; i < 8 && i < gseq.size(); i++) check("rr_order", gseq[i], (i % 2) ? 2 : 1);

        // M0 arrives during M2 block; M0 then M1
        do_reset(); lat_max = 2; gseq.delete();
        fork
            begin xfer(2, 8, 1, 32'h210, a2, e1); end
            begin
                repeat (5) @(posedge clk);
                fork
                    xfer(0, 1, 1, 32'h010, a0, e0);
                    xfer(1, 1, 1, 32'h110, a1, e1);
                join
            end
        join
        check("blk_acks_m2", a2, 8);
        check("blk_count", gseq.size(), 3);
        for (int i = 0; i < 3 && i < gseq.size(); i++) check("blk_order", gseq[i], (i == 0) ? 2 : (i == 1) ? 0 : 1);

        // slave error passed to owner
        do_reset(); err_next = 1;
        xfer(0, 1, 0, 32'h0, a0, e0);
        check("err_resp", {a0[7:0], e0[7:0]}, 16'h0001);

        // watchdog abort
        do_reset(); slv_mode = 1;
        raise_m1_read();
        @(negedge clk);
        @(negedge clk);
        k = 0;
        while (!tmo_o && k < 40) begin @(negedge clk); k++; end
        check("wd_latency", k, 16);
        check("wd_err", {m_err[1], m_ack[1], s_cyc_o, s_stb_o}, 4'b1000);
        @(posedge clk); #1 s_ack = 1;
        @(negedge clk);
        check("wd_late_ack", {m_ack[1], m_err[1], tmo_o, s_cyc_o}, 0);
        check("wd_abort_gnt", gnt_o, 1);
        @(posedge clk); #1;
        s_ack = 0; m_cyc[1] = 0; m_stb[1] = 0;
        @(negedge clk);
        @(negedge clk);
        check("wd_release", gnt_o, 3);

        // ack coincident with the threshold cycle
        do_reset(); slv_mode = 1;
        raise_m1_read();
        @(negedge clk);
        @(negedge clk);
        repeat (14) @(negedge clk);
        @(posedge clk); #1 s_ack = 1; s_dat = 32'h5a5a0001;
        @(negedge clk);
        check("co_ack", {m_ack[1], m_err[1], tmo_o}, 3'b100);
        check("co_dat", m_dat_o[1], 32'h5a5a0001);
        @(posedge clk); #1;
        s_ack = 0; m_cyc[1] = 0; m_stb[1] = 0;
        @(negedge clk);
        check("co_no_abort", {m_err[1], tmo_o}, 0);
        @(negedge clk);
        check("co_release", gnt_o, 3);

        // asynchronous reset while M2 owns the bus
        do_reset(); slv_mode = 1;
        @(posedge clk); #1;
        m_cyc[2] = 1; m_stb[2] = 1; m_adr[2] = 32'h220; m_sel[2] = 4'h3;
        @(negedge clk);
        @(negedge clk);
        check("ar_gnt_m2", gnt_o, 2);
        @(posedge clk); #2 rst = 1;
        #1;
        check("ar_gnt", gnt_o, 3);
        check("ar_s_bus", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o}, 0);
        m_cyc[2] = 0; m_stb[2] = 0;
        @(negedge clk); #2 rst = 0;
        slv_mode = 0; lat = 0;
        @(posedge clk); #1;
        m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 32'h0;
        @(negedge clk);
        check("ar_idle", gnt_o, 3);
        @(negedge clk);
        check("ar_m0_gnt", gnt_o, 0);
        @(posedge clk); #1;
        m_cyc[0] = 0; m_stb[0] = 0;
        repeat (3) @(posedge clk);

        // randomized concurrent traffic from all three masters
        do_reset(); lat_max = 3;
        fork
            rnd_master(0, 25);
            rnd_master(1, 25);
            rnd_master(2, 25);
        join
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
